seq_code_detector: RTL and testbench



---
 rtl/seq_code_detector.sv | 72 +++++++
 tb/tb_seq_code_detector.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_code_detector.sv
// Two-code serial detector; W-bit window vs CT1/CT2, registered match pulses; hit counters under SEQDET_HITCNT_EN.
// Latency: match one cycle after the completing bit's edge; no backpressure, din_valid gaps are transparent.
module seq_code_detector #(
  parameter int unsigned     W       = 4,
  parameter logic [W-1:0]    CT1     = W'(4'b0110),
  parameter logic [W-1:0]    CT2     = W'(4'b1011),
  parameter bit              OVERLAP = 1'b1,
  parameter int unsigned     CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din_valid,
  input  logic             din,
  output logic [1:0]       match,
  output logic [CNT_W-1:0] hit_cnt1,
  output logic [CNT_W-1:0] hit_cnt2
);

  localparam int unsigned    FW   = $clog2(W + 1);
  localparam logic [FW-1:0]  FULL = FW'(W);

  logic [W-1:0]  sr;
  logic [W-1:0]  sr_next;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_next;
  logic          armed;
  logic [1:0]    hit;

  assign sr_next   = {sr[W-2:0], din};
  assign fill_next = (fill == FULL) ? FULL : fill + 1'b1;
  assign armed     = (fill_next == FULL);
  assign hit       = {armed && (sr_next == CT2), armed && (sr_next == CT1)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      fill  <= '0;
      match <= 2'b00;
    end else if (clr) begin
      sr    <= '0;
      fill  <= '0;
      match <= 2'b00;
    end else if (din_valid) begin
      sr    <= sr_next;
      // Non-overlapping mode re-arms from scratch after any hit.
      fill  <= (!OVERLAP && (|hit)) ? '0 : fill_next;
      match <= hit;
    end else begin
      match <= 2'b00;
    end
  end

`ifdef SEQDET_HITCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt1 <= '0;
      hit_cnt2 <= '0;
    end else if (clr) begin
      hit_cnt1 <= '0;
      hit_cnt2 <= '0;
    end else if (din_valid) begin
      if (hit[0] && (hit_cnt1 != '1)) hit_cnt1 <= hit_cnt1 + 1'b1;
      if (hit[1] && (hit_cnt2 != '1)) hit_cnt2 <= hit_cnt2 + 1'b1;
    end
  end
`else
  assign hit_cnt1 = '0;
  assign hit_cnt2 = '0;
`endif

endmodule

// File: tb/tb_seq_code_detector.sv
// Directed bench for seq_code_detector: default, non-overlap and 2-bit-counter instances share one stimulus.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_code_detector;

`ifdef SEQDET_HITCNT_EN
  localparam bit HC = 1'b1;
`else
  localparam bit HC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;

  logic [1:0] m_a, m_b, m_c;
  logic [7:0] a1, a2, b1, b2;
  logic [1:0] c1, c2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_code_detector u_a (.clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
                         .match(m_a), .hit_cnt1(a1), .hit_cnt2(a2));
  seq_code_detector #(.OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid),
                         .din(din), .match(m_b), .hit_cnt1(b1), .hit_cnt2(b2));
  seq_code_detector #(.CNT_W(2)) u_c (.clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid),
                         .din(din), .match(m_c), .hit_cnt1(c1), .hit_cnt2(c2));

  task automatic drive(input logic b);
    din       = b;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_a, m_b, m_c} !== 6'b0) begin
      errors++;
      $display("FAIL reset_match: got %b/%b/%b expected 00/00/00", m_a, m_b, m_c);
    end
    checks++;
    if ({a1, a2, b1, b2, c1, c2} !== 36'b0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d %0d %0d %0d %0d %0d expected all 0", a1, a2, b1, b2, c1, c2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ct1();
    logic [3:0] bits;
    logic [1:0] exp [4];
    bits = 4'b0110;
    exp = '{2'b00, 2'b00, 2'b00, 2'b01};
    do_clr();
    for (int i = 0; i < 4; i++) begin
      drive(bits[3-i]);
      checks++;
      if (m_a !== exp[i]) begin
        errors++;
        $display("FAIL ct1_bit%0d: got %b expected %b", i + 1, m_a, exp[i]);
      end
    end
    checks++;
    if (int'(a1) !== (HC ? 1 : 0) || a2 !== 8'd0) begin
      errors++;
      $display("FAIL ct1_cnt: got %0d/%0d expected %0d/0", a1, a2, HC ? 1 : 0);
    end
    @(negedge clk);
    checks++;
    if (m_a !== 2'b00) begin
      errors++;
      $display("FAIL ct1_pulse_width: got %b expected 00", m_a);
    end
  endtask

  task automatic test_gap();
    do_clr();
    drive(1'b1);
    drive(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m_a !== 2'b00) begin
        errors++;
        $display("FAIL gap_idle%0d: got %b expected 00", i, m_a);
      end
    end
    drive(1'b1);
    checks++;
    if (m_a !== 2'b00) begin
      errors++;
      $display("FAIL gap_bit3: got %b expected 00", m_a);
    end
    drive(1'b1);
    checks++;
    if (m_a !== 2'b10) begin
      errors++;
      $display("FAIL gap_ct2: got %b expected 10", m_a);
    end
    checks++;
    if (int'(a2) !== (HC ? 1 : 0) || a1 !== 8'd0) begin
      errors++;
      $display("FAIL gap_cnt: got %0d/%0d expected 0/%0d", a1, a2, HC ? 1 : 0);
    end
    @(negedge clk);
    checks++;
    if (m_a !== 2'b00) begin
      errors++;
      $display("FAIL gap_pulse_width: got %b expected 00", m_a);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [1:0] exp_a [7];
    logic [1:0] exp_b [7];
    bits  = 7'b0110110;
    exp_a = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    exp_b = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    do_clr();
    for (int i = 0; i < 7; i++) begin
      drive(bits[6-i]);
      checks++;
      if (m_a !== exp_a[i]) begin
        errors++;
        $display("FAIL overlap_bit%0d: got %b expected %b", i + 1, m_a, exp_a[i]);
      end
      checks++;
      if (m_b !== exp_b[i]) begin
        errors++;
        $display("FAIL nooverlap_bit%0d: got %b expected %b", i + 1, m_b, exp_b[i]);
      end
    end
    checks++;
    if (int'(a1) !== (HC ? 2 : 0) || int'(a2) !== (HC ? 1 : 0)) begin
      errors++;
      $display("FAIL overlap_cnt: got %0d/%0d expected %0d/%0d", a1, a2, HC ? 2 : 0, HC ? 1 : 0);
    end
    checks++;
    if (int'(b1) !== (HC ? 1 : 0) || b2 !== 8'd0) begin
      errors++;
      $display("FAIL nooverlap_cnt: got %0d/%0d expected %0d/0", b1, b2, HC ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] bits;
    logic [1:0] exp [5];
    bits = 5'b00110;
    exp  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    do_clr();
    drive(1'b0);
    drive(1'b1);
    drive(1'b1);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_a !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_match: got %b expected 00", m_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(bits[4-i]);
      checks++;
      if (m_a !== exp[i]) begin
        errors++;
        $display("FAIL rstmid_bit%0d: got %b expected %b", i + 1, m_a, exp[i]);
      end
    end
  endtask

  task automatic test_clr_priority();
    logic [3:0] bits;
    logic [1:0] exp [4];
    bits = 4'b0110;
    exp  = '{2'b00, 2'b00, 2'b00, 2'b01};
    do_clr();
    drive(1'b0);
    drive(1'b1);
    drive(1'b1);
    clr       = 1'b1;
    din_valid = 1'b1;
    din       = 1'b0;
    @(negedge clk);
    clr       = 1'b0;
    din_valid = 1'b0;
    checks++;
    if (m_a !== 2'b00) begin
      errors++;
      $display("FAIL clr_match: got %b expected 00", m_a);
    end
    checks++;
    if (a1 !== 8'd0 || a2 !== 8'd0) begin
      errors++;
      $display("FAIL clr_cnt: got %0d/%0d expected 0/0", a1, a2);
    end
    for (int i = 0; i < 4; i++) begin
      drive(bits[3-i]);
      checks++;
      if (m_a !== exp[i]) begin
        errors++;
        $display("FAIL clr_after_bit%0d: got %b expected %b", i + 1, m_a, exp[i]);
      end
    end
  endtask

  task automatic test_saturate();
    do_clr();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) drive(1'b0);
      drive(1'b1);
      drive(1'b1);
      drive(1'b0);
      checks++;
      if (m_c[0] !== 1'b1) begin
        errors++;
        $display("FAIL sat_pulse%0d: got %b expected 1", k + 1, m_c[0]);
      end
      checks++;
      if (int'(c1) !== (HC ? ((k + 1 > 3) ? 3 : k + 1) : 0)) begin
        errors++;
        $display("FAIL sat_cnt%0d: got %0d expected %0d", k + 1, c1,
                 HC ? ((k + 1 > 3) ? 3 : k + 1) : 0);
      end
    end
    checks++;
    if (int'(a1) !== (HC ? 7 : 0) || int'(a2) !== (HC ? 6 : 0) || int'(c2) !== (HC ? 3 : 0)) begin
      errors++;
      $display("FAIL sat_totals: got %0d/%0d/%0d expected %0d/%0d/%0d", a1, a2, c2,
               HC ? 7 : 0, HC ? 6 : 0, HC ? 3 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_ct1();
    test_gap();
    test_overlap();
    test_reset_mid();
    test_clr_priority();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
